// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared register-file control constants and writeback source encoding
package rf_ctrl_pkg;
   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int REG_AW = 5;
   typedef enum logic {WB_ALU = 1'b0, WB_LSU = 1'b1} wb_src_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, bit 0 = ALU, bit 1 = LSU, pointer holds the last winner
module rr_arb2
   import rf_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] gnt
);
   wb_src_e last;
   // a lone requester wins; on a tie the side not granted last time wins
   always_comb begin
      gnt[1] = req[1] && (!req[0] || last == WB_ALU);
      gnt[0] = req[0] && !gnt[1];
   end
   // remember who won the most recent accepted transfer
   always_ff @(posedge clk or negedge rst)
      if (!rst) last <= WB_ALU;
      else if (adv) last <= gnt[1] ? WB_LSU : WB_ALU;
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: ALU/LSU writeback arbitration, registered write port and busy scoreboard; RF_WB_FWD_EN adds write-port forwarding
module regfile_wb_scheduler
   import rf_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic [REG_AW-1:0] chk_rs1,
   input  logic [REG_AW-1:0] chk_rs2,
   output logic              stall,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [REG_AW-1:0] lsu_rd,
   input  logic [XLEN-1:0]   lsu_data,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
`ifdef RF_WB_FWD_EN
   output logic              fwd1_hit,
   output logic              fwd2_hit,
   output logic [XLEN-1:0]   fwd_data,
`endif
   output logic [NREGS-1:0]  busy,
   output logic              wb_err
);
   logic [1:0]        gnt;
   logic              xfer, issue, raw1, raw2;
   logic [REG_AW-1:0] wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic [NREGS-1:0]  busy_nxt;

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({lsu_valid, alu_valid}),
      .adv (xfer),
      .gnt (gnt)
   );

   assign alu_ready = gnt[0];
   assign lsu_ready = gnt[1];
   assign xfer      = |gnt;
   assign wb_rd     = gnt[1] ? lsu_rd : alu_rd;
   assign wb_data   = gnt[1] ? lsu_data : alu_data;

`ifdef RF_WB_FWD_EN
   assign fwd1_hit = rf_we && rf_waddr == chk_rs1 && chk_rs1 != '0;
   assign fwd2_hit = rf_we && rf_waddr == chk_rs2 && chk_rs2 != '0;
   assign fwd_data = rf_wdata;
   assign raw1     = busy[chk_rs1] && chk_rs1 != '0 && !fwd1_hit;
   assign raw2     = busy[chk_rs2] && chk_rs2 != '0 && !fwd2_hit;
`else
   assign raw1     = busy[chk_rs1] && chk_rs1 != '0;
   assign raw2     = busy[chk_rs2] && chk_rs2 != '0;
`endif

   assign stall = raw1 || raw2 || (iss_valid && busy[iss_rd] && iss_rd != '0);
   assign issue = iss_valid && !stall && iss_rd != '0;

   // clear the register being written this cycle, then set the new destination so set wins
   always_comb begin
      busy_nxt = busy;
      if (rf_we) busy_nxt[rf_waddr] = 1'b0;
      if (issue) busy_nxt[iss_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // scoreboard register
   always_ff @(posedge clk or negedge rst)
      if (!rst) busy <= '0;
      else busy <= busy_nxt;

   // write-port register; x0 transfers are accepted but never written
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= xfer && wb_rd != '0;
         if (xfer) begin
            rf_waddr <= wb_rd;
            rf_wdata <= wb_data;
         end
      end

   // sticky flag for a writeback to a register nobody was waiting on
   always_ff @(posedge clk or negedge rst)
      if (!rst) wb_err <= 1'b0;
      else if (xfer && wb_rd != '0 && !busy[wb_rd]) wb_err <= 1'b1;
endmodule
